fifo_wrr_arbiter: RTL and testbench
===================================

Name: fifo_wrr_arbiter

Overview:
- Weighted round-robin arbiter that drains NUM_IN first-word fall-through FIFO queues into one shared output stream.
- Typical use: the scheduler in front of a shared downstream consumer (e.g. a PIFO insert port) that several per-flow FIFOs compete for.
- Grants one queue at a time for a burst of up to its programmed weight, then rotates priority.

Parameters:
- NUM_IN, 4, number of requesting queues (>=2).
- DATA_WIDTH, 64, width of each data word.
- WEIGHT_WIDTH, 4, width of each per-queue burst weight.
- ID_WIDTH, $clog2(NUM_IN), grant index width (derived localparam).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- i__data_in_valid  input  NUM_IN  per-queue valid (FIFO not-empty).
- ia__data_in  input  [DATA_WIDTH-1:0] x NUM_IN  per-queue head word.
- o__data_in_ready  output  NUM_IN  per-queue pop strobe/ready.
- ia__weight  input  [WEIGHT_WIDTH-1:0] x NUM_IN  per-queue burst length; quasi-static config.
- o__data_out_valid  output  1  shared output valid.
- o__data_out  output  DATA_WIDTH  shared output word.
- i__data_out_ready  input  1  downstream ready.
- o__grant_id  output  ID_WIDTH  currently granted queue.
- o__busy  output  1  high while in BURST state.

Behaviour:
- States: IDLE, BURST. Registers: r__state, r__grant_id, r__rr_ptr (ID_WIDTH), r__burst_cnt (WEIGHT_WIDTH).
- Reset values: state IDLE, grant_id 0, rr_ptr 0, burst_cnt 0. While reset is high, all o__data_in_ready=0, o__data_out_valid=0, o__busy=0, o__grant_id=0.
- Selection: rotating priority. Pick the first index j with valid[j]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_IN (wrap NUM_IN-1 -> 0; non-power-of-2 NUM_IN wraps at NUM_IN, not 2^ID_WIDTH).
- IDLE:
  - If any valid: latch grant_id=selected and burst_cnt=eff_weight(selected), where eff_weight = weight, or 1 if weight==0. Go to BURST.
  - No transfer occurs in IDLE (one-cycle arbitration latency from first valid to first output valid).
- BURST outputs (combinational):
  - o__data_out_valid = valid[grant_id]; o__data_out = ia__data_in[grant_id].
  - o__data_in_ready[k] = (k==grant_id) & i__data_out_ready; all other bits 0.
  - transfer = valid[grant_id] & i__data_out_ready.
- BURST release conditions:
  - transfer with burst_cnt==1 (weight exhausted), or
  - valid[grant_id]==0 (queue drained); this cycle carries no transfer.
- Otherwise: a transfer decrements burst_cnt; no transfer leaves it unchanged. A stalled downstream holds the grant indefinitely.
- On release:
  - rr_ptr <= grant_id+1 mod NUM_IN.
  - Same edge: re-select using the new pointer over current valids. If any valid, stay in BURST with the new grant_id/burst_cnt (zero-bubble handoff). Else go to IDLE.
  - The released queue is considered last. If it is the only valid requester it is re-granted; if it then turns out empty it releases on the next cycle.
- Weight changes take effect only at the next grant. burst_cnt never underflows.
- Outside BURST: o__data_out_valid=0, o__data_in_ready=0, o__data_out=ia__data_in[grant_id] (don't-care).
- Reset mid-burst: returns to IDLE next edge, pointer back to 0; no partial state is retained. The upstream FIFO sees ready=0 during reset, so no pop is lost.
- Data throughput: 1 word/cycle sustained within and across bursts when queues stay non-empty.

Decomposition:
- Package fifo_arb_pkg:
  - typedef enum logic [0:0] {ARB_IDLE, ARB_BURST} arb_state_t.
  - function eff_weight (zero -> 1).
- Sub-module rr_priority_select (NUM_IN param), purely combinational:
  - Inputs: request vector, rr_ptr.
  - Outputs: o__any, o__sel_id.
  - Implementation: double-width masked priority encode.
- The FSM, counters and output muxing live in fifo_wrr_arbiter.

Test Plan:
- Single requester: valid=4'b0001, weight[0]=3, ready=1, 5 words queued -> grant 0 from cycle 2.
  - Words 1-3 transfer, then release with rr_ptr=1 and re-grant to 0.
  - Words 4-5 transfer, release on empty, IDLE.
- All four valid, weights {1,2,3,4}, ready=1, deep queues -> output ids 0,1,1,2,2,2,3,3,3,3,0,... with no bubble between bursts.
- Backpressure: grant 2 with weight 4, toggle i__data_out_ready 1,0,0,1,1,1 -> exactly 4 transfers counted, grant held across stalls, then rotates to 3.
- Early drain: weight[1]=8 with only 2 words queued, queue 3 valid -> 2 transfers, 1 idle cycle (valid low), then grant 3.
- Wrap and zero weight: NUM_IN=3, rr_ptr=2, valids {0,1,2}, weight[2]=0 -> grant 2 for exactly 1 word, then grant 0.
- Reset mid-burst: assert reset during grant 1 with burst_cnt=2 -> next cycle state IDLE, rr_ptr=0, all ready/valid 0; after deassert, grant restarts from queue 0.

Source files
------------

// File: rtl/fifo_wrr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin FIFO arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {ARB_IDLE, ARB_BURST} arb_state_t;

  // A zero weight still grants one word so a queue can never be starved.
  function automatic int unsigned eff_weight(input int unsigned weight);
    return (weight == 0) ? 1 : weight;
  endfunction

endpackage

// File: rtl/fifo_wrr_arbiter_rr_select.sv
// Rotating-priority selector: first requester at or after rr_ptr, wrapping at NUM_IN.
module rr_priority_select #(
  parameter  int NUM_IN   = 4,
  localparam int ID_WIDTH = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0]   i__req,
  input  logic [ID_WIDTH-1:0] i__rr_ptr,
  output logic                o__any,
  output logic [ID_WIDTH-1:0] o__sel_id
);

  logic [2*NUM_IN-1:0] req_dbl;
  logic [2*NUM_IN-1:0] mask;
  logic [2*NUM_IN-1:0] masked;

  // Lower copy is masked below the pointer; upper copy supplies the wrap-around.
  always_comb begin
    req_dbl = {i__req, i__req};
    for (int i = 0; i < 2*NUM_IN; i++) mask[i] = (i >= int'(i__rr_ptr));
    masked = req_dbl & mask;
    o__sel_id = '0;
    for (int i = 2*NUM_IN-1; i >= 0; i--)
      if (masked[i]) o__sel_id = ID_WIDTH'(i % NUM_IN);
  end

  assign o__any = |i__req;

endmodule

// File: rtl/fifo_wrr_arbiter.sv
// Weighted round-robin arbiter draining NUM_IN FWFT queues into one stream;
// each grant lasts up to its queue's weight in words, then priority rotates.
module fifo_wrr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_IN       = 4,
  parameter  int DATA_WIDTH   = 64,
  parameter  int WEIGHT_WIDTH = 4,
  localparam int ID_WIDTH     = $clog2(NUM_IN)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_IN-1:0]                    i__data_in_valid,
  input  logic [NUM_IN-1:0][DATA_WIDTH-1:0]    ia__data_in,
  output logic [NUM_IN-1:0]                    o__data_in_ready,
  input  logic [NUM_IN-1:0][WEIGHT_WIDTH-1:0]  ia__weight,
  output logic                                 o__data_out_valid,
  output logic [DATA_WIDTH-1:0]                o__data_out,
  input  logic                                 i__data_out_ready,
  output logic [ID_WIDTH-1:0]                  o__grant_id,
  output logic                                 o__busy
);

  arb_state_t              r__state;
  logic [ID_WIDTH-1:0]     r__grant_id;
  logic [ID_WIDTH-1:0]     r__rr_ptr;
  logic [WEIGHT_WIDTH-1:0] r__burst_cnt;

  logic                    busy;
  logic                    cur_valid;
  logic                    transfer;
  logic                    rel;
  logic [ID_WIDTH-1:0]     next_ptr;
  logic [ID_WIDTH-1:0]     sel_ptr;
  logic [ID_WIDTH-1:0]     sel_id;
  logic                    sel_any;
  logic [WEIGHT_WIDTH-1:0] sel_weight;

  assign busy      = (r__state == ARB_BURST) & ~reset;
  assign cur_valid = i__data_in_valid[r__grant_id];
  assign transfer  = busy & cur_valid & i__data_out_ready;
  assign rel       = busy & ((transfer & (r__burst_cnt == WEIGHT_WIDTH'(1))) | ~cur_valid);
  assign next_ptr  = (r__grant_id == ID_WIDTH'(NUM_IN-1)) ? '0 : r__grant_id + 1'b1;

  // On release the selector already sees the advanced pointer, giving a bubble-free handoff.
  assign sel_ptr = rel ? next_ptr : r__rr_ptr;

  rr_priority_select #(.NUM_IN(NUM_IN)) u_sel (
    .i__req    (i__data_in_valid),
    .i__rr_ptr (sel_ptr),
    .o__any    (sel_any),
    .o__sel_id (sel_id)
  );

  assign sel_weight = WEIGHT_WIDTH'(eff_weight(32'(ia__weight[sel_id])));

  always_ff @(posedge clk) begin
    if (reset) begin
      r__state     <= ARB_IDLE;
      r__grant_id  <= '0;
      r__rr_ptr    <= '0;
      r__burst_cnt <= '0;
    end else begin
      case (r__state)
        ARB_IDLE: begin
          if (sel_any) begin
            r__state     <= ARB_BURST;
            r__grant_id  <= sel_id;
            r__burst_cnt <= sel_weight;
          end
        end
        ARB_BURST: begin
          if (rel) begin
            r__rr_ptr <= next_ptr;
            if (sel_any) begin
              r__grant_id  <= sel_id;
              r__burst_cnt <= sel_weight;
            end else begin
              r__state <= ARB_IDLE;
            end
          end else if (transfer) begin
            r__burst_cnt <= r__burst_cnt - 1'b1;
          end
        end
        default: r__state <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    o__data_in_ready = '0;
    if (busy && i__data_out_ready) o__data_in_ready[r__grant_id] = 1'b1;
  end

  assign o__data_out_valid = busy & cur_valid;
  assign o__data_out      = ia__data_in[r__grant_id];
  assign o__grant_id      = reset ? '0 : r__grant_id;
  assign o__busy          = busy;

endmodule

// File: tb/tb_fifo_wrr_arbiter.sv
// Checks a 4-input and a 3-input arbiter against a queue-level scheduling model.
module tb_fifo_wrr_arbiter;

  localparam int DW = 16;
  localparam int WW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]         v  [2];
  logic [3:0][DW-1:0] d  [2];
  logic [3:0][WW-1:0] w  [2];
  logic               dr [2];

  logic [3:0]    rdy_a, ov_a_w;
  logic [2:0]    rdy_b;
  logic          ov_a, ov_b, busy_a, busy_b;
  logic [DW-1:0] od_a, od_b;
  logic [1:0]    gid_a, gid_b;

  fifo_wrr_arbiter #(.NUM_IN(4), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)) dut_a (
    .clk(clk), .reset(rst),
    .i__data_in_valid(v[0]), .ia__data_in(d[0]), .o__data_in_ready(rdy_a),
    .ia__weight(w[0]), .o__data_out_valid(ov_a), .o__data_out(od_a),
    .i__data_out_ready(dr[0]), .o__grant_id(gid_a), .o__busy(busy_a)
  );

  fifo_wrr_arbiter #(.NUM_IN(3), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)) dut_b (
    .clk(clk), .reset(rst),
    .i__data_in_valid(v[1][2:0]), .ia__data_in(d[1][2:0]), .o__data_in_ready(rdy_b),
    .ia__weight(w[1][2:0]), .o__data_out_valid(ov_b), .o__data_out(od_b),
    .i__data_out_ready(dr[1]), .o__grant_id(gid_b), .o__busy(busy_b)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Environment FIFOs: word content is a pure function of (instance, queue, sequence).
  int pushed [2][4];
  int popped [2][4];

  // Scheduling model: who holds the grant, words left in the burst, rotation pointer.
  bit mb [2];
  int mg [2];
  int mp [2];
  int mc [2];

  bit rec [2];
  int seen0[$];
  int seen1[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(int i, int q, int s);
    return DW'((i << 14) | (q << 12) | (s & 12'hfff));
  endfunction

  function automatic int nq(int i);
    return (i == 0) ? 4 : 3;
  endfunction

  function automatic int effw(int x);
    return (x == 0) ? 1 : x;
  endfunction

  function automatic int pick(int i, int ptr);
    int n = nq(i);
    for (int k = 0; k < n; k++)
      if (v[i][(ptr + k) % n]) return (ptr + k) % n;
    return -1;
  endfunction

  task automatic push(int i, int q, int cnt);
    pushed[i][q] += cnt;
  endtask

  task automatic cycle();
    for (int i = 0; i < 2; i++)
      for (int q = 0; q < 4; q++) begin
        v[i][q] = (q < nq(i)) && (pushed[i][q] > popped[i][q]);
        d[i][q] = word(i, q, popped[i][q]);
      end
    #1;
    for (int i = 0; i < 2; i++) begin
      logic [3:0]    g_rdy;
      logic          g_v, g_b;
      logic [DW-1:0] g_d;
      logic [1:0]    g_g;
      bit            eb, ev, xf;
      int            s;
      g_rdy = (i == 0) ? rdy_a  : {1'b0, rdy_b};
      g_v   = (i == 0) ? ov_a   : ov_b;
      g_b   = (i == 0) ? busy_a : busy_b;
      g_d   = (i == 0) ? od_a   : od_b;
      g_g   = (i == 0) ? gid_a  : gid_b;
      eb = mb[i] && !rst;
      ev = eb && v[i][mg[i]];
      chk($sformatf("i%0d busy", i),  32'(g_b), 32'(eb));
      chk($sformatf("i%0d grant", i), 32'(g_g), rst ? 0 : mg[i]);
      chk($sformatf("i%0d dvalid", i), 32'(g_v), 32'(ev));
      chk($sformatf("i%0d ready", i), 32'(g_rdy), (eb && dr[i]) ? (1 << mg[i]) : 0);
      if (ev) chk($sformatf("i%0d data", i), 32'(g_d), 32'(word(i, mg[i], popped[i][mg[i]])));
      if (rec[i] && g_v && dr[i]) begin
        if (i == 0) seen0.push_back(int'(g_g)); else seen1.push_back(int'(g_g));
      end
      for (int q = 0; q < nq(i); q++)
        if (g_rdy[q] && v[i][q]) popped[i][q]++;
      // advance the model across the coming edge
      if (rst) begin
        mb[i] = 0; mg[i] = 0; mp[i] = 0; mc[i] = 0;
      end else if (!mb[i]) begin
        s = pick(i, mp[i]);
        if (s >= 0) begin mb[i] = 1; mg[i] = s; mc[i] = effw(int'(w[i][s])); end
      end else begin
        xf = v[i][mg[i]] && dr[i];
        if ((xf && mc[i] == 1) || !v[i][mg[i]]) begin
          mp[i] = (mg[i] + 1) % nq(i);
          s = pick(i, mp[i]);
          if (s >= 0) begin mg[i] = s; mc[i] = effw(int'(w[i][s])); end
          else mb[i] = 0;
        end else if (xf) begin
          mc[i]--;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  int tbl_a[10] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};
  int tbl_b[8]  = '{0, 1, 2, 0, 0, 1, 1, 2};

  initial begin
    for (int i = 0; i < 2; i++) begin
      mb[i] = 0; mg[i] = 0; mp[i] = 0; mc[i] = 0; rec[i] = 0;
      dr[i] = 1'b1; w[i] = '0; v[i] = '0; d[i] = '0;
      for (int q = 0; q < 4; q++) begin pushed[i][q] = 0; popped[i][q] = 0; end
    end
    rst = 1'b1;
    run(2);
    rst = 1'b0;

    // single requester: weight 3, five words
    w[0][0] = 4'd3;
    push(0, 0, 5);
    run(10);
    chk("single drained", 32'(popped[0][0]), 5);

    // four deep queues, weights 1..4, continuous ready
    rst = 1'b1; run(1); rst = 1'b0;
    w[0] = {4'd4, 4'd3, 4'd2, 4'd1};
    for (int q = 0; q < 4; q++) push(0, q, 12);
    rec[0] = 1;
    run(60);
    rec[0] = 0;
    for (int k = 0; k < 10; k++)
      chk($sformatf("wrr seq %0d", k), (seen0.size() > k) ? seen0[k] : 99, tbl_a[k]);
    chk("wrr total", 32'(seen0.size()), 48);

    // three-input wrap with a zero weight
    w[1] = {4'd0, 4'd0, 4'd2, 4'd2};
    rec[1] = 1;
    push(1, 0, 1); push(1, 1, 1);
    run(6);
    for (int q = 0; q < 3; q++) push(1, q, 2);
    run(14);
    rec[1] = 0;
    for (int k = 0; k < 8; k++)
      chk($sformatf("wrap seq %0d", k), (seen1.size() > k) ? seen1[k] : 99, tbl_b[k]);

    // randomized traffic, backpressure, weight changes and occasional resets
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(149) == 0);
      for (int i = 0; i < 2; i++) begin
        dr[i] = ($urandom_range(3) != 0);
        if ($urandom_range(1) == 0) begin
          int q = $urandom_range(nq(i) - 1);
          if (pushed[i][q] - popped[i][q] < 6) push(i, q, 1 + $urandom_range(1));
        end
        if ($urandom_range(49) == 0) w[i][$urandom_range(nq(i) - 1)] = WW'($urandom_range(5));
      end
      cycle();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
